// File: rtl/slave_link_pkg.sv
// slave_link_pkg: shared types and widths for the slave serial link receiver
package slave_link_pkg;

    typedef enum logic [1:0] {
        WAIT_CS,
        IDLE,
        SHIFT,
        CHECK
    } rx_state_t;

    localparam int FRAME_BITS = 5;
    localparam int DATA_W     = 4;
    localparam int CNT_W      = 3;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage single-bit synchronizer with selectable reset value
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= {STAGES{RST_VAL}};
        else        r <= {r[STAGES-2:0], d};
    end

    assign q = r[STAGES-1];

endmodule

// File: rtl/slave_nibble_rx.sv
// slave_nibble_rx: deserializes parity-protected 5-bit frames into a stable nibble
module slave_nibble_rx
    import slave_link_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter int          TIMEOUT_CYC  = 50000,
    parameter logic [3:0]  RESET_NIBBLE = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_in,
    input  logic              cs_n_in,
    input  logic              mosi_in,
    output logic [DATA_W-1:0] nibble,
    output logic              nibble_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_BITS);

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_d, cs_n_d;
    logic sclk_rise, cs_fall, cs_rise;
    logic [SYNC_STAGES-1:0] prime;
    logic primed;

    rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [FRAME_BITS-1:0] shreg, shreg_nxt;
    logic                  overrun, overrun_nxt;
    logic [TO_W-1:0]       to_cnt, to_cnt_nxt;
    logic [DATA_W-1:0]     nibble_nxt;
    logic                  nv_nxt, fe_nxt;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk_in), .q(sclk_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst_n(rst_n), .d(cs_n_in), .q(cs_n_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi_in), .q(mosi_s));

    // delayed copies for edge detection; prime marks when the synchronizers
    // hold real pin samples rather than their reset values, so WAIT_CS cannot
    // be fooled by the reset-high cs_n chain while a frame is still running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            cs_n_d <= 1'b1;
            prime  <= '0;
        end else begin
            sclk_d <= sclk_s;
            cs_n_d <= cs_n_s;
            prime  <= {prime[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = ~cs_n_s & cs_n_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;
    assign primed    = prime[SYNC_STAGES-1];
    assign busy      = (state == SHIFT) || (state == WAIT_CS);

    // state, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_CS;
            bit_cnt      <= '0;
            shreg        <= '0;
            overrun      <= 1'b0;
            to_cnt       <= '0;
            nibble       <= RESET_NIBBLE;
            nibble_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shreg        <= shreg_nxt;
            overrun      <= overrun_nxt;
            to_cnt       <= to_cnt_nxt;
            nibble       <= nibble_nxt;
            nibble_valid <= nv_nxt;
            frame_err    <= fe_nxt;
        end
    end

    // next-state logic; IDLE starts on cs_n level so a fall seen during CHECK is not lost
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        overrun_nxt = overrun;
        to_cnt_nxt  = to_cnt;
        nibble_nxt  = nibble;
        nv_nxt      = 1'b0;
        fe_nxt      = 1'b0;
        case (state)
            WAIT_CS: state_nxt = (primed && cs_n_s) ? IDLE : WAIT_CS;
            IDLE: begin
                if (!cs_n_s || cs_fall) begin
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = '0;
                    overrun_nxt = 1'b0;
                    to_cnt_nxt  = '0;
                end
            end
            SHIFT: begin
                to_cnt_nxt = to_cnt + 1'b1;
                if (sclk_rise) begin
                    to_cnt_nxt  = '0;
                    bit_cnt_nxt = (bit_cnt < FULL_CNT) ? bit_cnt + 1'b1 : bit_cnt;
                    shreg_nxt   = (bit_cnt < FULL_CNT) ? {shreg[FRAME_BITS-2:0], mosi_s} : shreg;
                    overrun_nxt = overrun | (bit_cnt >= FULL_CNT);
                end
                if (cs_rise) begin
                    state_nxt = CHECK;
                end else if (!sclk_rise && to_cnt == TO_LAST) begin
                    fe_nxt    = 1'b1;
                    state_nxt = WAIT_CS;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (bit_cnt == FULL_CNT && !overrun && !(^shreg)) begin
                    nibble_nxt = shreg[FRAME_BITS-1:1];
                    nv_nxt     = 1'b1;
                end else begin
                    fe_nxt = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_slave_nibble_rx.sv
// tb_slave_nibble_rx: scoreboard bench for the slave nibble receiver
module tb_slave_nibble_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk_in = 1'b0;
    logic       cs_n_in = 1'b1;
    logic       mosi_in = 1'b0;
    logic [3:0] nibble;
    logic       nibble_valid, frame_err, busy;

    typedef struct {
        logic       err;
        logic [3:0] nib;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    slave_nibble_rx #(.SYNC_STAGES(2), .TIMEOUT_CYC(20), .RESET_NIBBLE(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
        .nibble(nibble), .nibble_valid(nibble_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (nibble_valid || frame_err)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, nibble_valid, frame_err}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {30'd0, nibble_valid, frame_err}, {30'd0, !e.err, e.err});
                check("pulse_nibble", {28'd0, nibble}, {28'd0, e.nib});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi_in = b;
        wait_cyc(4);
        sclk_in = 1'b1;
        wait_cyc(4);
        sclk_in = 1'b0;
    endtask

    task automatic frame(input logic [5:0] bits, input int n);
        cs_n_in = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < n; i++) send_bit(bits[n-1-i]);
        wait_cyc(4);
        cs_n_in = 1'b1;
        wait_cyc(12);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            sclk_in = 1'($urandom);
            cs_n_in = 1'($urandom);
            mosi_in = 1'($urandom);
            @(negedge clk);
        end
        check("rst_nibble", {28'd0, nibble}, 32'h0);
        check("rst_valid", {31'd0, nibble_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        sclk_in = 1'b0;
        cs_n_in = 1'b1;
        mosi_in = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(4);
        check("busy_after_release", {31'd0, busy}, 32'd0);

        q.push_back('{1'b0, 4'hB});
        frame(6'b010111, 5);
        q.push_back('{1'b0, 4'h5});
        frame(6'b001010, 5);
        check("nibble_5", {28'd0, nibble}, 32'h5);

        q.push_back('{1'b1, 4'h5});
        frame(6'b001101, 5);
        q.push_back('{1'b1, 4'h5});
        frame(6'b001011, 4);
        q.push_back('{1'b1, 4'h5});
        frame(6'b101110, 6);
        check("nibble_kept", {28'd0, nibble}, 32'h5);

        q.push_back('{1'b1, 4'h5});
        cs_n_in = 1'b0;
        wait_cyc(6);
        send_bit(1'b1);
        send_bit(1'b0);
        wait_cyc(30);
        check("busy_after_timeout", {31'd0, busy}, 32'd1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        cs_n_in = 1'b1;
        wait_cyc(12);
        q.push_back('{1'b0, 4'h3});
        frame(6'b000110, 5);
        check("nibble_3", {28'd0, nibble}, 32'h3);

        cs_n_in = 1'b0;
        wait_cyc(6);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        check("midrst_nibble", {28'd0, nibble}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(6);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        wait_cyc(4);
        cs_n_in = 1'b1;
        wait_cyc(12);
        check("midrst_no_update", {28'd0, nibble}, 32'h0);
        q.push_back('{1'b0, 4'hC});
        frame(6'b011000, 5);
        check("nibble_C", {28'd0, nibble}, 32'hC);

        wait_cyc(20);
        check("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
